// File: rtl/sd_defines.sv
// Shared definitions for the SD clock sequencer.
// Holds the divider width, default parameter values, counter widths and the
// sequencer state encoding.
package sd_defines;

  localparam int unsigned SD_DIV_W       = 8;
  localparam int unsigned SD_HOLD_W      = 4;
  localparam int unsigned SD_EDGE_W      = 8;
  localparam int unsigned SD_INIT_CYCLES = 80;
  localparam int unsigned SD_HOLD_CYCLES = 2;

  localparam logic [SD_DIV_W-1:0] SD_DIV_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LOW = 2'd1,
    HOLD     = 2'd2,
    INIT     = 2'd3
  } sd_clk_state_e;

endpackage

// File: rtl/sd_clk_edge_det.sv
// Edge detector on the divided SD clock level fed back from the divider.
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   sd_clk_in  - divided clock level
//   rise, fall - combinational single-cycle edge strobes
module sd_clk_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sd_clk_in,
  output logic rise,
  output logic fall
);

  logic clk_q;

  // Previous-cycle level of the SD clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clk_q <= 1'b0;
    else     clk_q <= sd_clk_in;
  end

  assign rise = sd_clk_in & ~clk_q;
  assign fall = ~sd_clk_in & clk_q;

endmodule

// File: rtl/sd_clk_ctrl.sv
// SD clock divider sequencer.
// Owns the divider value, reprograms it only while the SD clock is low and the
// bus is idle (holding the divider in reset for HOLD_CYCLES), and emits the
// card power-up clock train of INIT_CYCLES rising edges on request.
// Optional build macro: SD_CLK_AUTOGATE_EN stops the SD clock low while the
// controller is idle with no bus activity and no pending request.
// Ports:
//   CLK, RST            - system clock, asynchronous active-high reset
//   DIV_REQ, DIV_NEW    - divider change request pulse and new value
//   INIT_REQ            - init clock train request pulse
//   CLK_EN              - host SD clock output enable
//   BUSY                - command/data engine mid-transfer
//   SD_CLK_IN           - divided clock level from the divider
//   DIVIDER, DIV_RST    - divider value and divider reset
//   SD_CLK_OE           - SD clock pad enable
//   DIV_ACK, INIT_DONE  - completion pulses
//   CTRL_BUSY           - sequencer not idle
module sd_clk_ctrl
  import sd_defines::*;
#(
  parameter logic [SD_DIV_W-1:0] DIV_DEFAULT = SD_DIV_DEFAULT,
  parameter int unsigned         INIT_CYCLES = SD_INIT_CYCLES,
  parameter int unsigned         HOLD_CYCLES = SD_HOLD_CYCLES
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                DIV_REQ,
  input  logic [SD_DIV_W-1:0] DIV_NEW,
  input  logic                INIT_REQ,
  input  logic                CLK_EN,
  input  logic                BUSY,
  input  logic                SD_CLK_IN,
  output logic [SD_DIV_W-1:0] DIVIDER,
  output logic                DIV_RST,
  output logic                SD_CLK_OE,
  output logic                DIV_ACK,
  output logic                INIT_DONE,
  output logic                CTRL_BUSY
);

  localparam logic [SD_HOLD_W-1:0] HOLD_LOAD = SD_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SD_EDGE_W-1:0] INIT_LAST = SD_EDGE_W'(INIT_CYCLES - 1);
  localparam logic [SD_EDGE_W-1:0] INIT_SAT  = SD_EDGE_W'(INIT_CYCLES);

  sd_clk_state_e       state_q, state_d;
  logic                div_pend_q, div_pend_d;
  logic                init_pend_q, init_pend_d;
  logic [SD_DIV_W-1:0] div_buf_q, div_buf_d;
  logic [SD_HOLD_W-1:0] hold_q, hold_d;
  logic [SD_EDGE_W-1:0] edge_q, edge_d;
  logic [SD_DIV_W-1:0] divider_d;
  logic                div_rst_d, oe_d, ack_d, done_d, busy_d;
  logic                rise, fall;

  sd_clk_edge_det u_edge (
    .clk       (CLK),
    .rst       (RST),
    .sd_clk_in (SD_CLK_IN),
    .rise      (rise),
    .fall      (fall)
  );

`ifdef SD_CLK_AUTOGATE_EN
  logic gate_q, gate_d;
`endif

  // Next-state, request latches and next output values.
  always_comb begin
    state_d     = state_q;
    div_pend_d  = div_pend_q;
    init_pend_d = init_pend_q;
    div_buf_d   = div_buf_q;
    hold_d      = hold_q;
    edge_d      = edge_q;
    divider_d   = DIVIDER;
    div_rst_d   = DIV_RST;
    ack_d       = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (div_pend_q && !BUSY) begin
          state_d    = WAIT_LOW;
          div_pend_d = 1'b0;
        end else if (init_pend_q) begin
          state_d     = INIT;
          init_pend_d = 1'b0;
          edge_d      = '0;
        end
      end
      WAIT_LOW: begin
        // Switch only just after the SD clock went low, so the change is glitch-free.
        if (fall && !BUSY) begin
          state_d   = HOLD;
          divider_d = div_buf_q;
          div_rst_d = 1'b1;
          hold_d    = HOLD_LOAD;
        end
      end
      HOLD: begin
        div_rst_d = 1'b1;
        if (hold_q == '0) begin
          state_d   = IDLE;
          div_rst_d = 1'b0;
          ack_d     = 1'b1;
        end else begin
          hold_d = hold_q - SD_HOLD_W'(1);
        end
      end
      INIT: begin
        if (rise) begin
          if (edge_q == INIT_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            edge_d  = INIT_SAT;
          end else begin
            edge_d = edge_q + SD_EDGE_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new divider request wins over the clear on start: latest value must be applied.
    if (DIV_REQ) begin
      div_pend_d = 1'b1;
      div_buf_d  = DIV_NEW;
    end
    // Init requests while the train is running (or starting) are duplicates.
    if (INIT_REQ && state_q != INIT && state_d != INIT) init_pend_d = 1'b1;

    busy_d = (state_d != IDLE);

`ifdef SD_CLK_AUTOGATE_EN
    // Park the clock low once a fall is seen while fully quiet; any activity releases it.
    gate_d = (state_q == IDLE) && (state_d == IDLE) && !BUSY &&
             !div_pend_q && !init_pend_q && !DIV_REQ && !INIT_REQ &&
             (gate_q || fall);
    oe_d   = !gate_d && (CLK_EN || (state_d == INIT));
`else
    oe_d   = CLK_EN || (state_d == INIT);
`endif
  end

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      div_pend_q  <= 1'b0;
      init_pend_q <= 1'b0;
      div_buf_q   <= DIV_DEFAULT;
      hold_q      <= '0;
      edge_q      <= '0;
      DIVIDER     <= DIV_DEFAULT;
      DIV_RST     <= 1'b0;
      SD_CLK_OE   <= 1'b0;
      DIV_ACK     <= 1'b0;
      INIT_DONE   <= 1'b0;
      CTRL_BUSY   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_pend_q  <= div_pend_d;
      init_pend_q <= init_pend_d;
      div_buf_q   <= div_buf_d;
      hold_q      <= hold_d;
      edge_q      <= edge_d;
      DIVIDER     <= divider_d;
      DIV_RST     <= div_rst_d;
      SD_CLK_OE   <= oe_d;
      DIV_ACK     <= ack_d;
      INIT_DONE   <= done_d;
      CTRL_BUSY   <= busy_d;
    end
  end

`ifdef SD_CLK_AUTOGATE_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) gate_q <= 1'b0;
    else     gate_q <= gate_d;
  end
`endif

endmodule

// File: tb/tb_sd_clk_ctrl.sv
// Self-checking bench for sd_clk_ctrl with a simple clock divider model.
module tb_sd_clk_ctrl;
  import sd_defines::*;

  localparam int unsigned HOLD  = 2;
  localparam int unsigned NINIT = 80;

  logic       CLK = 1'b0;
  logic       RST, DIV_REQ, INIT_REQ, CLK_EN, BUSY, SD_CLK_IN;
  logic [7:0] DIV_NEW, DIVIDER;
  logic       DIV_RST, SD_CLK_OE, DIV_ACK, INIT_DONE, CTRL_BUSY;

  int n_chk = 0;
  int n_err = 0;
  logic prev_sd = 1'b0;
  logic rise_now = 1'b0;
  logic fall_now = 1'b0;
  logic [7:0] dcnt;

  always #5 CLK = ~CLK;

  // Divider model: half period of DIVIDER+1 cycles, held low while DIV_RST.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      dcnt <= 8'd0; SD_CLK_IN <= 1'b0;
    end else if (DIV_RST) begin
      dcnt <= 8'd0; SD_CLK_IN <= 1'b0;
    end else if (dcnt >= DIVIDER) begin
      dcnt <= 8'd0; SD_CLK_IN <= ~SD_CLK_IN;
    end else begin
      dcnt <= dcnt + 8'd1;
    end
  end

  sd_clk_ctrl dut (
    .CLK(CLK), .RST(RST), .DIV_REQ(DIV_REQ), .DIV_NEW(DIV_NEW),
    .INIT_REQ(INIT_REQ), .CLK_EN(CLK_EN), .BUSY(BUSY), .SD_CLK_IN(SD_CLK_IN),
    .DIVIDER(DIVIDER), .DIV_RST(DIV_RST), .SD_CLK_OE(SD_CLK_OE),
    .DIV_ACK(DIV_ACK), .INIT_DONE(INIT_DONE), .CTRL_BUSY(CTRL_BUSY)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next sample point and classify the SD clock edge of that cycle.
  task automatic cyc();
    @(negedge CLK);
    rise_now = SD_CLK_IN && !prev_sd;
    fall_now = !SD_CLK_IN && prev_sd;
    prev_sd  = SD_CLK_IN;
  endtask

  // Wait for a divider change already requested to take effect and verify it.
  task automatic finish_div(input logic [7:0] v, input string tag);
    logic got = 1'b0;
    logic pf  = 1'b0;
    int   width = 1;
    for (int n = 0; n < 2000; n++) begin
      cyc();
      if (DIV_RST) begin got = 1'b1; break; end
      pf = fall_now;
    end
    check({tag, "_rst_seen"}, 32'(got), 32'd1);
    if (!got) return;
    check({tag, "_rst_after_fall"}, 32'(pf), 32'd1);
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (!DIV_RST) break;
      width++;
    end
    check({tag, "_rst_width"}, 32'(width), 32'(HOLD));
    check({tag, "_ack"}, 32'(DIV_ACK), 32'd1);
    check({tag, "_divider"}, 32'(DIVIDER), 32'(v));
    cyc();
    check({tag, "_ack_pulse"}, 32'(DIV_ACK), 32'd0);
  endtask

  task automatic do_div(input logic [7:0] v, input string tag);
    DIV_NEW = v; DIV_REQ = 1'b1;
    cyc();
    DIV_REQ = 1'b0; DIV_NEW = 8'($urandom);
    finish_div(v, tag);
  endtask

  // Count rises while the train runs; period 0 disables the interval check.
  task automatic count_init(input string tag, input int period);
    int   rises = 0, bad = 0, oe_low = 0, last = -1, busy_after = 0;
    logic got = 1'b0;
    logic first_oe = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      INIT_REQ = 1'b0;
      cyc();
      if (n == 0) first_oe = SD_CLK_OE;
      if (INIT_DONE) begin got = 1'b1; break; end
      if (!SD_CLK_OE) oe_low++;
      if (SD_CLK_OE && rise_now) begin
        rises++;
        if (period != 0 && last >= 0 && (n - last) != period) bad++;
        last = n;
        if (rises == 20) INIT_REQ = 1'b1;
      end
    end
    INIT_REQ = 1'b0;
    check({tag, "_first_oe"}, 32'(first_oe), 32'd1);
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_rises"}, 32'(rises), 32'(NINIT));
    check({tag, "_oe_low_mid"}, 32'(oe_low), 32'd0);
    check({tag, "_oe_after"}, 32'(SD_CLK_OE), 32'd0);
    if (period != 0) check({tag, "_bad_interval"}, 32'(bad), 32'd0);
    cyc();
    check({tag, "_done_pulse"}, 32'(INIT_DONE), 32'd0);
    for (int n = 0; n < 10; n++) begin
      cyc();
      if (CTRL_BUSY) busy_after++;
    end
    check({tag, "_no_restart"}, 32'(busy_after), 32'd0);
  endtask

  initial begin
    int   busy_rst, gap, pre_oe, stray;
    logic got;
    logic [7:0] d0;

    RST = 1'b1; DIV_REQ = 1'b0; INIT_REQ = 1'b0; CLK_EN = 1'b0; BUSY = 1'b0; DIV_NEW = 8'd0;
    repeat (3) cyc();
    RST = 1'b0;
    cyc(); cyc();
    check("rst_divider", 32'(DIVIDER), 32'hFF);
    check("rst_div_rst", 32'(DIV_RST), 32'd0);
    check("rst_oe", 32'(SD_CLK_OE), 32'd0);
    check("rst_ack", 32'(DIV_ACK), 32'd0);
    check("rst_done", 32'(INIT_DONE), 32'd0);
    check("rst_busy", 32'(CTRL_BUSY), 32'd0);

    do_div(8'h04, "div04");

    // Busy hold-off: two requests while busy, last value wins after BUSY drops.
    BUSY = 1'b1; busy_rst = 0; d0 = DIVIDER;
    gap = int'($urandom_range(5, 30));
    for (int i = 0; i < 50; i++) begin
      DIV_REQ = 1'b0;
      if (i == 3)       begin DIV_REQ = 1'b1; DIV_NEW = 8'h10; end
      if (i == 3 + gap) begin DIV_REQ = 1'b1; DIV_NEW = 8'h20; end
      cyc();
      if (DIV_RST) busy_rst++;
    end
    DIV_REQ = 1'b0;
    check("busy_no_rst", 32'(busy_rst), 32'd0);
    check("busy_divider_kept", 32'(DIVIDER), 32'(d0));
    check("busy_ctrl_idle", 32'(CTRL_BUSY), 32'd0);
    BUSY = 1'b0;
    finish_div(8'h20, "busy20");

    for (int r = 0; r < 3; r++) do_div(8'($urandom_range(1, 6)), "div_rand");
    do_div(8'h04, "div04b");

    // Init train with the host enable off.
    CLK_EN = 1'b0; INIT_REQ = 1'b1;
    cyc();
    INIT_REQ = 1'b0;
    count_init("init", 0);

    // Simultaneous requests: divider change completes before the train starts.
    DIV_NEW = 8'h02; DIV_REQ = 1'b1; INIT_REQ = 1'b1;
    cyc();
    DIV_REQ = 1'b0; INIT_REQ = 1'b0;
    got = 1'b0; pre_oe = 0;
    for (int n = 0; n < 2000; n++) begin
      cyc();
      if (DIV_ACK) begin got = 1'b1; break; end
      if (SD_CLK_OE) pre_oe++;
    end
    check("sim_ack_seen", 32'(got), 32'd1);
    check("sim_no_init_before_ack", 32'(pre_oe), 32'd0);
    check("sim_oe_at_ack", 32'(SD_CLK_OE), 32'd0);
    check("sim_divider", 32'(DIVIDER), 32'h02);
    count_init("sim_init", 2 * (2 + 1));

`ifdef SD_CLK_AUTOGATE_EN
    CLK_EN = 1'b1; BUSY = 1'b1;
    cyc(); cyc();
    check("ag_oe_busy", 32'(SD_CLK_OE), 32'd1);
    for (int n = 0; n < 100 && !SD_CLK_IN; n++) cyc();
    BUSY = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      cyc();
      if (fall_now) begin got = 1'b1; break; end
    end
    check("ag_fall_seen", 32'(got), 32'd1);
    check("ag_oe_at_fall", 32'(SD_CLK_OE), 32'd1);
    cyc();
    check("ag_oe_dropped", 32'(SD_CLK_OE), 32'd0);
    repeat (20) cyc();
    check("ag_oe_stays_low", 32'(SD_CLK_OE), 32'd0);
    BUSY = 1'b1;
    cyc();
    check("ag_oe_restored", 32'(SD_CLK_OE), 32'd1);
    BUSY = 1'b0;
`else
    CLK_EN = 1'b1; BUSY = 1'b0; pre_oe = 0; stray = 0;
    cyc();
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (!SD_CLK_OE) pre_oe++;
      if (fall_now) stray++;
    end
    check("oe_follows_en", 32'(pre_oe), 32'd0);
    check("oe_falls_seen", 32'(stray > 0), 32'd1);
`endif
    CLK_EN = 1'b0;
    cyc(); cyc();

    // Reset in the middle of the hold window.
    DIV_NEW = 8'h05; DIV_REQ = 1'b1;
    cyc();
    DIV_REQ = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      cyc();
      if (DIV_RST) begin got = 1'b1; break; end
    end
    check("mid_hold_reached", 32'(got), 32'd1);
    RST = 1'b1;
    #1;
    check("mid_rst_divider", 32'(DIVIDER), 32'hFF);
    check("mid_rst_div_rst", 32'(DIV_RST), 32'd0);
    check("mid_rst_busy", 32'(CTRL_BUSY), 32'd0);
    check("mid_rst_oe", 32'(SD_CLK_OE), 32'd0);
    cyc(); cyc();
    RST = 1'b0;
    stray = 0;
    for (int n = 0; n < 600; n++) begin
      cyc();
      if (DIV_RST || DIV_ACK || CTRL_BUSY) stray++;
    end
    check("mid_rst_pending_lost", 32'(stray), 32'd0);
    check("mid_rst_divider_after", 32'(DIVIDER), 32'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
